// File: rtl/data_upload.sv
// SPI file upload: streams RAM bytes from BASE_ADDR back to the IO controller on sdo.
// Optional UPLOAD_CHECKSUM_EN appends an 8-bit sum byte once count reaches len.
module data_upload #(
  parameter logic [24:0] BASE_ADDR  = 25'h200000,
  parameter logic [7:0]  CMD_RX     = 8'h56,
  parameter logic [7:0]  CMD_RX_DAT = 8'h57
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sck,
  input  logic        ss,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  input  logic [24:0] len,
  output logic        uploading,
  output logic [24:0] count,
  output logic        rd,
  output logic [24:0] a,
  input  logic [7:0]  q,
  input  logic        rd_ack,
`ifdef UPLOAD_CHECKSUM_EN
  output logic [7:0]  checksum,
`endif
  output logic        underrun
);

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_BUSY,
    RD_DROP
  } rd_st_t;

  rd_st_t st, st_nx;

  logic [1:0]  sck_s, ss_s, sdi_s;
  logic        sck_d;
  logic        sck_rise, sck_fall, ss_hi;
  logic [3:0]  cnt;
  logic [6:0]  sr_in;
  logic [7:0]  cmd;
  logic [6:0]  sr_out;
  logic [7:0]  pf_data;
  logic        pf_valid;
  logic [24:0] a_off;
  logic        past_len, in_range;
  logic        start, stop, load, shift;
  logic        want_rd, capture;
  logic [7:0]  load_byte;
  logic        load_adv, load_urun;
`ifdef UPLOAD_CHECKSUM_EN
  logic        csum_sent, load_cs;
`endif

  assign sck_rise = sck_s[1] & ~sck_d;
  assign sck_fall = ~sck_s[1] & sck_d;
  assign ss_hi    = ss_s[1];

  assign start = sck_rise & ~ss_hi & (cnt == 4'd15)
               & (cmd == CMD_RX) & sdi_s[1];
  assign stop  = sck_rise & ~ss_hi & (cnt == 4'd15)
               & (cmd == CMD_RX) & ~sdi_s[1];

  // cnt reads 8 right after the last bit of the previous byte
  assign load  = sck_fall & ~ss_hi & (cnt == 4'd8)
               & (cmd == CMD_RX_DAT);
  assign shift = sck_fall & ~ss_hi & (cnt > 4'd8)
               & (cmd == CMD_RX_DAT);

  assign a_off    = a - BASE_ADDR;
  assign in_range = a_off < len;
  assign past_len = count >= len;

  assign want_rd = uploading & ~pf_valid & in_range
                 & ~past_len & ~start & ~stop;
  assign capture = (st == RD_BUSY) & rd_ack & ~start & ~stop;
  assign rd      = (st != RD_IDLE);

  always_comb begin
    st_nx = st;
    unique case (st)
      RD_IDLE: if (want_rd) st_nx = RD_BUSY;
      RD_BUSY: begin
        if (rd_ack)            st_nx = RD_IDLE;
        else if (start | stop) st_nx = RD_DROP;
      end
      RD_DROP: if (rd_ack) st_nx = RD_IDLE;
      default: st_nx = RD_IDLE;
    endcase
  end

  always_comb begin
    load_byte = 8'h00;
    load_adv  = 1'b0;
    load_urun = 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
    load_cs   = 1'b0;
`endif
    if (!uploading) begin
      load_byte = 8'h00;
    end else if (past_len) begin
`ifdef UPLOAD_CHECKSUM_EN
      load_byte = csum_sent ? 8'h00 : checksum;
      load_cs   = ~csum_sent;
`else
      load_byte = 8'h00;
`endif
    end else if (!pf_valid) begin
      load_adv  = 1'b1;
      load_urun = 1'b1;
    end else begin
      load_byte = pf_data;
      load_adv  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st <= RD_IDLE;
    else          st <= st_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_s     <= 2'b00;
      ss_s      <= 2'b11;
      sdi_s     <= 2'b00;
      sck_d     <= 1'b0;
      cnt       <= 4'd0;
      sr_in     <= 7'd0;
      cmd       <= 8'h00;
      sr_out    <= 7'd0;
      sdo       <= 1'b0;
      sdo_oe    <= 1'b0;
      pf_data   <= 8'h00;
      pf_valid  <= 1'b0;
      uploading <= 1'b0;
      count     <= 25'd0;
      a         <= BASE_ADDR;
      underrun  <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
      checksum  <= 8'h00;
      csum_sent <= 1'b0;
`endif
    end else begin
      sck_s <= {sck_s[0], sck};
      ss_s  <= {ss_s[0], ss};
      sdi_s <= {sdi_s[0], sdi};
      sck_d <= sck_s[1];

      if (ss_hi) begin
        cnt    <= 4'd0;
        sdo_oe <= 1'b0;
      end else if (sck_rise) begin
        sr_in <= {sr_in[5:0], sdi_s[1]};
        if (cnt == 4'd7) cmd <= {sr_in, sdi_s[1]};
        cnt <= (cnt == 4'd15) ? 4'd8 : cnt + 4'd1;
      end

      if (load) begin
        sr_out <= load_byte[6:0];
        sdo    <= load_byte[7];
        if (uploading) sdo_oe <= 1'b1;
        if (load_adv) begin
          count    <= count + 25'd1;
          pf_valid <= 1'b0;
        end
        if (load_urun) underrun <= 1'b1;
`ifdef UPLOAD_CHECKSUM_EN
        // the checksum byte itself is not summed
        if (load_cs) csum_sent <= 1'b1;
        else         checksum  <= checksum + load_byte;
`endif
      end else if (shift) begin
        sr_out <= {sr_out[5:0], 1'b0};
        sdo    <= sr_out[6];
      end

      // a fill landing with a load wins over the load's clear
      if (capture) begin
        pf_data  <= q;
        pf_valid <= 1'b1;
        a        <= a + 25'd1;
      end

      if (stop) uploading <= 1'b0;

      if (start) begin
        uploading <= 1'b1;
        a         <= BASE_ADDR;
        count     <= 25'd0;
        underrun  <= 1'b0;
        pf_valid  <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
        checksum  <= 8'h00;
        csum_sent <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: doc/data_upload.md
Name: data_upload

Overview:
- Reverse path of the SPI file download block: streams a RAM region back to the IO controller over the same SPI slave link, e.g. tape save of the 2 MB tape buffer.
- The IO controller clocks bytes out and the core shifts RAM bytes out on sdo.
- Single-clock design: sck/ss/sdi are synchronised and edge-detected in the clk domain.
- Sits beside the download block on the shared SPI pins and RAM arbiter.

Parameters:
- BASE_ADDR, 25'h200000, first RAM address read on upload start.
- CMD_RX, 8'h56, UIO_FILE_RX command (start/stop).
- CMD_RX_DAT, 8'h57, UIO_FILE_RX_DAT command (data stream).

Ports:
- clk  in  1  system clock; sck period ≥ 8 clk periods required.
- reset_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock from IO controller.
- ss  in  1  SPI select, active high = deselected.
- sdi  in  1  SPI data in.
- sdo  out  1  SPI data out, MSB first.
- sdo_oe  out  1  high while CMD_RX_DAT data bytes are being shifted.
- len  in  25  number of valid bytes to upload.
- uploading  out  1  upload session active.
- count  out  25  bytes shifted out in current session.
- rd  out  1  RAM read request, held until rd_ack.
- a  out  25  RAM read address.
- q  in  8  RAM read data, valid in cycle rd_ack=1.
- rd_ack  in  1  RAM read acknowledge.
- underrun  out  1  sticky: a byte was due before its prefetch completed.

Behaviour:
- Reset values: sdo=0, sdo_oe=0, uploading=0, count=0, rd=0, a=BASE_ADDR, underrun=0. Internal bit counter=0, prefetch_valid=0.
- Input sync: sck, ss, sdi each pass through 2 flops. sck rise/fall are derived from the synchronised value.
- ss high (synchronised) forces bit counter to 0 and sdo_oe=0. Session state (uploading, address, count) is retained.
- Bit counter on each sck rise: counts 0..7 for the command byte, then 8..15 repeating for data bytes. sdi is shifted in MSB first. At cnt 7 the command register latches.
- CMD_RX, bit 15 rise:
  - sdi=1: start session. uploading=1, a=BASE_ADDR, count=0, underrun=0, prefetch_valid=0, then issue a read.
  - sdi=0: stop session. uploading=0. Any outstanding read completes and is discarded.
- Prefetch:
  - When uploading=1, prefetch_valid=0, rd=0 and a < BASE_ADDR+len: assert rd.
  - On rd_ack: capture q into the prefetch buffer, set prefetch_valid=1, drop rd the next cycle, and increment a.
  - rd is never dropped before rd_ack.
- Byte load, CMD_RX_DAT with uploading=1:
  - Trigger: sck fall following cnt 7, or following cnt 15 of the previous data byte.
  - Load the shift register and set sdo to bit 7. prefetch_valid=0, count+1.
  - If prefetch_valid=0 at load: load 8'h00 and set underrun.
  - If count ≥ len: load 8'h00, count is not incremented, no RAM read is issued, underrun is not set.
- Shifting: each subsequent sck fall within the byte shifts the next bit onto sdo. sdo_oe=1 from load until ss rises.
- CMD_RX_DAT with uploading=0: sdo=0 throughout, no reads issued.
- Simultaneous events:
  - rd_ack in the same cycle as a byte load: the load uses the old prefetch state (underrun if it was empty), then the buffer fills.
  - Stop command during an outstanding read: rd held until ack, data dropped.
- reset_n low mid-transfer: all state returns to reset values immediately, rd drops regardless of ack.
- Arithmetic: a and count are 25-bit and wrap modulo 2^25; no saturation.

Optional Feature:
- UPLOAD_CHECKSUM_EN: adds output checksum[7:0], the 8-bit sum modulo 256 of all bytes actually loaded (including 0x00 padding). Cleared on session start and on reset.
- With CMD_RX_DAT sent while ss is held low after the data, the checksum is clocked out as an extra byte after count reaches len.
- Without the macro: no checksum port. Bytes past len are 0x00.

Test Plan:
- Start (0x56,0x01), RAM holds 0x200000=0xA5, 0x200001=0x3C, len=2, rd_ack 2 clk after rd; 0x57 plus 2 bytes -> sdo yields 0xA5, 0x3C; count=2; underrun=0; a=0x200002.
- Same session, one more byte clocked -> 0x00 returned, no rd pulse, count stays 2.
- rd_ack withheld until after the first data byte load -> first byte 0x00, underrun=1, next byte = late data.
- Stop (0x56,0x00) while rd outstanding -> rd held until ack, uploading=0 next cycle, later 0x57 returns 0x00.
- reset_n pulsed low mid-byte -> sdo=0, rd=0, count=0, uploading=0 asynchronously.
- UPLOAD_CHECKSUM_EN, bytes 0xA5,0x3C, len=2 -> third byte = 0xE1.
